// File: rtl/and_vector_checker.sv
// and_vector_checker
//   Response-side checker for a bitwise-AND DUT. It accepts (a, b, dut_out)
//   triples over a valid/ready handshake and compares dut_out against a & b.
//   It counts accepted vectors and mismatches and captures the first failing
//   triple. After the programmed number of vectors it reports done and pass.
//
// Ports
//   clk, rst_n      clock; synchronous active-low reset
//   start           one-cycle pulse that begins a run (accepted in IDLE/DONE)
//   num_vectors     vectors expected in the run, sampled on accepted start
//   in_valid/ready  vector handshake; ready is high only in RUN
//   a, b, dut_out   operands and the DUT response to check
//   busy/done/pass  RUN / DONE / DONE with no mismatch
//   count_total     vectors accepted this run
//   count_err       mismatching vectors this run (saturating)
//   err_flag        at least one mismatch this run
//   first_err_*     a, b and dut_out of the first mismatching vector
module and_vector_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vectors,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] count_total,
  output logic [CNT_W-1:0] count_err,
  output logic             err_flag,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] first_err_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE     = 1;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] nv_q;
  logic [CNT_W-1:0] total_inc;
  logic [WIDTH-1:0] exp_out;
  logic             start_ok;
  logic             accept;
  logic             mismatch;
  logic             last_vec;

  assign exp_out   = a & b;
  assign total_inc = count_total + ONE;
  // This accept is the one that brings the run up to the programmed count.
  assign last_vec  = (total_inc == nv_q);
  assign accept    = in_valid & in_ready;
  assign mismatch  = accept & (dut_out != exp_out);
  assign pass      = done & ~err_flag;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded outputs. in_ready depends on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    start_ok  = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          start_ok  = 1'b1;
          // A zero-length run completes immediately with pass set.
          state_nxt = (num_vectors == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        // start is deliberately not looked at here: a run cannot be restarted.
        if (in_valid && last_vec) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result datapath: cleared by reset and by every accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nv_q          <= '0;
      count_total   <= '0;
      count_err     <= '0;
      err_flag      <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_out <= '0;
    end else if (start_ok) begin
      nv_q          <= num_vectors;
      count_total   <= '0;
      count_err     <= '0;
      err_flag      <= 1'b0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_out <= '0;
    end else if (accept) begin
      count_total <= total_inc;
      if (mismatch) begin
        if (count_err != ERR_MAX) count_err <= count_err + ONE;
        // Only the first failing triple of a run is kept.
        if (!err_flag) begin
          err_flag      <= 1'b1;
          first_err_a   <= a;
          first_err_b   <= b;
          first_err_out <= dut_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_and_vector_checker.sv
// Testbench for and_vector_checker: directed scenarios plus randomized runs,
// checked every cycle against a transaction-level reference model.
module tb_and_vector_checker;
  localparam int W = 4;
  localparam int C = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, in_valid, in_ready;
  logic [C-1:0] num_vectors;
  logic [W-1:0] a, b, dut_out;
  logic         busy, done, pass, err_flag;
  logic [C-1:0] count_total, count_err;
  logic [W-1:0] first_err_a, first_err_b, first_err_out;

  // Narrow-counter instance for the CNT_W = 2 scenario
  logic         s2_start, s2_valid, s2_ready, s2_busy, s2_done, s2_pass, s2_err;
  logic [1:0]   s2_nv, s2_total, s2_cerr;
  logic [W-1:0] s2_a, s2_b, s2_o, s2_fa, s2_fb, s2_fo;

  and_vector_checker #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .count_total(count_total),
    .count_err(count_err), .err_flag(err_flag), .first_err_a(first_err_a),
    .first_err_b(first_err_b), .first_err_out(first_err_out));

  and_vector_checker #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(s2_start), .num_vectors(s2_nv),
    .in_valid(s2_valid), .in_ready(s2_ready), .a(s2_a), .b(s2_b), .dut_out(s2_o),
    .busy(s2_busy), .done(s2_done), .pass(s2_pass), .count_total(s2_total),
    .count_err(s2_cerr), .err_flag(s2_err), .first_err_a(s2_fa),
    .first_err_b(s2_fb), .first_err_out(s2_fo));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: run phase plus the list-level statistics of a run.
  int         m_st;   // 0 idle, 1 running, 2 finished
  int         m_nv, m_tot, m_mis;
  bit         m_err;
  logic [W-1:0] m_fa, m_fb, m_fo;

  task automatic model_clear();
    m_tot = 0; m_mis = 0; m_err = 0; m_fa = 0; m_fb = 0; m_fo = 0;
  endtask

  task automatic check_outs(input string tag);
    int emis;
    emis = (m_mis > 255) ? 255 : m_mis;
    chk({tag, ".busy"},  busy,        m_st == 1);
    chk({tag, ".done"},  done,        m_st == 2);
    chk({tag, ".pass"},  pass,        (m_st == 2) && !m_err);
    chk({tag, ".ready"}, in_ready,    m_st == 1);
    chk({tag, ".total"}, count_total, m_tot);
    chk({tag, ".cerr"},  count_err,   emis);
    chk({tag, ".eflag"}, err_flag,    m_err);
    chk({tag, ".fa"},    first_err_a, m_fa);
    chk({tag, ".fb"},    first_err_b, m_fb);
    chk({tag, ".fo"},    first_err_out, m_fo);
  endtask

  // One clock cycle with the given inputs; model advances, outputs checked.
  task automatic cyc(input string tag, input bit st, input int nv, input bit v,
                     input logic [W-1:0] va, input logic [W-1:0] vb, input logic [W-1:0] vo);
    start = st; num_vectors = C'(nv); in_valid = v; a = va; b = vb; dut_out = vo;
    if (st && m_st != 1) begin
      model_clear();
      m_nv = nv;
      m_st = (nv == 0) ? 2 : 1;
    end else if (v && m_st == 1) begin
      m_tot++;
      if (vo != (va & vb)) begin
        m_mis++;
        if (!m_err) begin m_err = 1; m_fa = va; m_fb = vb; m_fo = vo; end
      end
      if (m_tot == m_nv) m_st = 2;
    end
    @(posedge clk); #1;
    start = 0; in_valid = 0;
    check_outs(tag);
  endtask

  task automatic idle_cyc(input string tag);
    cyc(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    m_st = 0; model_clear();
    check_outs(tag);
  endtask

  initial begin
    rst_n = 0; start = 0; in_valid = 0; num_vectors = 0; a = 0; b = 0; dut_out = 0;
    s2_start = 0; s2_valid = 0; s2_nv = 0; s2_a = 0; s2_b = 0; s2_o = 0;
    m_st = 0; m_nv = 0; model_clear();
    @(posedge clk); @(posedge clk); #1;
    do_reset("rst");

    // 1: clean 5-vector run
    cyc("s1", 1, 5, 0, 0, 0, 0);
    cyc("s1", 0, 0, 1, 0, 0, 0);
    cyc("s1", 0, 0, 1, 2, 0, 0);
    cyc("s1", 0, 0, 1, 3, 1, 1);
    cyc("s1", 0, 0, 1, 4, 1, 0);
    cyc("s1", 0, 0, 1, 3, 2, 2);
    chk("s1_done", done, 1); chk("s1_total", count_total, 5);
    chk("s1_cerr", count_err, 0); chk("s1_pass", pass, 1); chk("s1_ready", in_ready, 0);

    // 2: mismatches on 3rd and 5th vectors
    cyc("s2", 1, 5, 0, 0, 0, 0);
    cyc("s2", 0, 0, 1, 0, 0, 0);
    cyc("s2", 0, 0, 1, 2, 0, 0);
    cyc("s2", 0, 0, 1, 3, 1, 3);
    cyc("s2", 0, 0, 1, 4, 1, 0);
    cyc("s2", 0, 0, 1, 3, 2, 0);
    chk("s2_cerr", count_err, 2); chk("s2_eflag", err_flag, 1);
    chk("s2_fa", first_err_a, 3); chk("s2_fb", first_err_b, 1);
    chk("s2_fo", first_err_out, 3); chk("s2_pass", pass, 0);

    // 3: gaps and a mid-run start pulse
    cyc("s3", 1, 5, 0, 0, 0, 0);
    cyc("s3", 0, 0, 1, 0, 0, 0);
    repeat (3) idle_cyc("s3gap");
    cyc("s3", 0, 0, 1, 2, 0, 0);
    cyc("s3st", 1, 9, 0, 0, 0, 0);
    repeat (2) idle_cyc("s3gap");
    cyc("s3", 0, 0, 1, 3, 1, 1);
    repeat (3) idle_cyc("s3gap");
    cyc("s3", 0, 0, 1, 4, 1, 0);
    cyc("s3", 0, 0, 1, 3, 2, 2);
    chk("s3_total", count_total, 5); chk("s3_pass", pass, 1);

    // 4: zero-length run, then a 2-vector run from DONE
    cyc("s4z", 1, 0, 0, 0, 0, 0);
    chk("s4_done", done, 1); chk("s4_total", count_total, 0); chk("s4_pass", pass, 1);
    cyc("s4dv", 0, 0, 1, 1, 1, 0);
    cyc("s4", 1, 2, 0, 0, 0, 0);
    chk("s4_busy", busy, 1);
    cyc("s4", 0, 0, 1, 5, 6, 4);
    cyc("s4", 0, 0, 1, 7, 7, 7);

    // 5: reset mid-run
    cyc("s5", 1, 5, 0, 0, 0, 0);
    cyc("s5", 0, 0, 1, 1, 1, 0);
    cyc("s5", 0, 0, 1, 2, 2, 2);
    in_valid = 1; a = 3; b = 3; dut_out = 1;
    do_reset("s5rst");
    chk("s5_total", count_total, 0); chk("s5_busy", busy, 0);
    idle_cyc("s5idle");
    cyc("s5b", 1, 2, 0, 0, 0, 0);
    cyc("s5b", 0, 0, 1, 9, 12, 8);
    cyc("s5b", 0, 0, 1, 15, 0, 0);
    chk("s5_pass", pass, 1);

    // Randomized runs with gaps, stray starts and random faults
    for (int r = 0; r < 40; r++) begin
      int nv, n;
      nv = $urandom_range(0, 12);
      cyc("rnd_st", 1, nv, 0, 0, 0, 0);
      n = 0;
      while (m_st == 1 && n < 200) begin
        logic [W-1:0] ra, rb, ro;
        ra = W'($urandom); rb = W'($urandom);
        ro = ($urandom_range(0, 3) == 0) ? W'($urandom) : (ra & rb);
        cyc("rnd", ($urandom_range(0, 9) == 0), $urandom_range(0, 20),
            ($urandom_range(0, 9) < 7), ra, rb, ro);
        n++;
      end
      chk("rnd_timeout", n < 200, 1);
      repeat ($urandom_range(0, 2)) cyc("rnd_done", 0, 0, 1, W'($urandom), W'($urandom), W'($urandom));
    end

    // 6: CNT_W = 2, three mismatches then in_valid held high
    s2_start = 1; s2_nv = 3;
    @(posedge clk); #1; s2_start = 0;
    chk("c2_busy", s2_busy, 1);
    s2_valid = 1;
    s2_a = 1; s2_b = 1; s2_o = 0; @(posedge clk); #1;
    s2_a = 3; s2_b = 3; s2_o = 1; @(posedge clk); #1;
    s2_a = 6; s2_b = 4; s2_o = 5; @(posedge clk); #1;
    chk("c2_done", s2_done, 1); chk("c2_total", s2_total, 3);
    chk("c2_cerr", s2_cerr, 3); chk("c2_ready", s2_ready, 0);
    s2_a = 2; s2_b = 2; s2_o = 0;
    repeat (3) @(posedge clk); #1;
    s2_valid = 0;
    chk("c2_total_hold", s2_total, 3); chk("c2_cerr_hold", s2_cerr, 3);
    chk("c2_fa", s2_fa, 1); chk("c2_fb", s2_fb, 1); chk("c2_fo", s2_fo, 0);
    chk("c2_pass", s2_pass, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
